// File: rtl/elevator_ctrl.sv
// Elevator car controller: latches floor calls, moves one floor per TRAVEL_TICKS, holds the door for DOOR_TICKS.
// Optional emergency stop input guarded by `ifdef ELEV_ESTOP_EN.
module elevator_ctrl #(
    parameter int N_FLOORS     = 4,
    parameter int TRAVEL_TICKS = 8,
    parameter int DOOR_TICKS   = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [N_FLOORS-1:0] CALL,
`ifdef ELEV_ESTOP_EN
    input  logic                STOP,
`endif
    output logic [1:0]          FLOOR,
    output logic [N_FLOORS-1:0] PENDING,
    output logic                DOOR_OPEN,
    output logic                Q1,
    output logic                Q0
);

    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int CW = $clog2(MAX_TICKS) + 1;
    localparam logic [CW-1:0] T_LAST = CW'(TRAVEL_TICKS - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DOOR_TICKS - 1);

    // Encodings double as the {Q1,Q0} status code.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_DOOR = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          floor_q, floor_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic                dir_up_q, dir_up_d;
    logic [CW-1:0]       tcnt_q, tcnt_d;
    logic [CW-1:0]       dcnt_q, dcnt_d;
    logic                door_open_q, door_open_d;
    logic [1:0]          q_q, q_d;

    logic                stop_w;
    logic [N_FLOORS-1:0] latched;
    logic [N_FLOORS-1:0] clr;
    logic [1:0]          arr_floor;

`ifdef ELEV_ESTOP_EN
    assign stop_w = STOP;
`else
    assign stop_w = 1'b0;
`endif

    function automatic logic [N_FLOORS-1:0] onehot(input logic [1:0] f);
        logic [N_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (int'(f) == i) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_above(input logic [N_FLOORS-1:0] p, input logic [1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(f)) r = r | p[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] p, input logic [1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i < int'(f)) r = r | p[i];
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        tcnt_d    = tcnt_q;
        dcnt_d    = dcnt_q;
        clr       = '0;
        arr_floor = floor_q;
        latched   = pending_q | CALL;

        if (!stop_w) begin
            case (state_q)
                S_IDLE: begin
                    tcnt_d = '0;
                    if ((pending_q & onehot(floor_q)) != '0) begin
                        state_d = S_DOOR;
                        dcnt_d  = '0;
                        clr     = onehot(floor_q);
                    end else if (dir_up_q && any_above(pending_q, floor_q)) begin
                        state_d = S_UP;
                    end else if (!dir_up_q && any_below(pending_q, floor_q)) begin
                        state_d = S_DOWN;
                    end else if (any_above(pending_q, floor_q)) begin
                        dir_up_d = 1'b1;
                        state_d  = S_UP;
                    end else if (any_below(pending_q, floor_q)) begin
                        dir_up_d = 1'b0;
                        state_d  = S_DOWN;
                    end
                end
                S_UP, S_DOWN: begin
                    if (tcnt_q == T_LAST) begin
                        tcnt_d    = '0;
                        arr_floor = (state_q == S_UP) ? 2'(floor_q + 2'd1) : 2'(floor_q - 2'd1);
                        floor_d   = arr_floor;
                        // Stop test sees this cycle's CALL so a late call still catches the car.
                        if ((latched & onehot(arr_floor)) != '0) begin
                            state_d = S_DOOR;
                            dcnt_d  = '0;
                            clr     = onehot(arr_floor);
                        end else if ((state_q == S_UP) ? any_above(latched, arr_floor)
                                                       : any_below(latched, arr_floor)) begin
                            state_d = state_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                end
                S_DOOR: begin
                    if ((CALL & onehot(floor_q)) != '0) begin
                        dcnt_d = '0;
                        clr    = onehot(floor_q);
                    end else if (dcnt_q == D_LAST) begin
                        state_d = S_IDLE;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        pending_d   = latched & ~clr;
        door_open_d = (state_d == S_DOOR);
        q_d         = state_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            floor_q     <= '0;
            pending_q   <= '0;
            dir_up_q    <= 1'b1;
            tcnt_q      <= '0;
            dcnt_q      <= '0;
            door_open_q <= 1'b0;
            q_q         <= 2'b00;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            pending_q   <= pending_d;
            dir_up_q    <= dir_up_d;
            tcnt_q      <= tcnt_d;
            dcnt_q      <= dcnt_d;
            door_open_q <= door_open_d;
            q_q         <= q_d;
        end
    end

    assign FLOOR     = floor_q;
    assign PENDING   = pending_q;
    assign DOOR_OPEN = door_open_q;
    assign Q1        = q_q[1];
    assign Q0        = q_q[0];

endmodule
